// File: rtl/sram_controller.sv
// sram_controller
//   Multi-cycle data-memory responder for the MEM stage of the pipelined core.
//   Each 32-bit access is split into two half-word cycles on an external
//   16-bit asynchronous SRAM; `ready` is held low while an access is running
//   so the pipeline freezes.
//
//   Optional feature macro: SRAM_FAST_WRITE_EN
//     defined   -> writes go WR_HI -> DONE directly (DONE at T3)
//     undefined -> reads and writes both take ACCESS_CYCLES cycles
//
// Parameters
//   ACCESS_CYCLES  cycles from request to DONE (3..15)
//   BASE_ADDR      byte address mapped to SRAM word 0
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   rd_en, wr_en     MEM-stage read / write request (write wins if both)
//   address          word-aligned byte address
//   write_data       store data
//   read_data        registered load result
//   ready            1 = pipeline may advance, 0 = freeze
//   sram_addr        SRAM half-word address
//   sram_dq          SRAM data bus (driven only in write cycles)
//   sram_we_n/oe_n   SRAM write / output enable, active-low
//   sram_ce_n/ub_n/lb_n  tied low
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_WAIT,
    S_DONE
  } state_t;

  // WAIT exits when the counter reads 0, so ACCESS_CYCLES-4 gives
  // ACCESS_CYCLES-3 cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (ACCESS_CYCLES > 3) ? 4'(ACCESS_CYCLES - 4) : '0;
  localparam bit         NO_WAIT   = (ACCESS_CYCLES <= 3);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q;
  logic [16:0] word_in;
  logic        bus_drive;
  logic [15:0] bus_half;

  assign word_in = 17'((address - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en)      state_d = S_WR_LO;
        else if (rd_en) state_d = S_RD_LO;
      end
      S_RD_LO: state_d = S_RD_HI;
      S_WR_LO: state_d = S_WR_HI;
      S_RD_HI: begin
        if (NO_WAIT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WR_HI: begin
`ifdef SRAM_FAST_WRITE_EN
        state_d = S_DONE;
`else
        if (NO_WAIT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
`endif
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      sram_addr <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Address and data are captured once, on leaving IDLE; the SRAM
      // address is kept in a register so it is stable for the whole cycle.
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        sram_addr <= {word_in, 1'b0};
        wdata_q   <= write_data;
      end
      if (state_q == S_RD_LO || state_q == S_WR_LO) sram_addr[0] <= 1'b1;
      if (state_q == S_RD_LO) read_data[15:0]  <= sram_dq;
      if (state_q == S_RD_HI) read_data[31:16] <= sram_dq;
    end
  end

  assign bus_drive = (state_q == S_WR_LO) || (state_q == S_WR_HI);
  assign bus_half  = (state_q == S_WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq   = bus_drive ? bus_half : 16'hzzzz;

  assign sram_we_n = !bus_drive;
  assign sram_oe_n = !((state_q == S_RD_LO) || (state_q == S_RD_HI));
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  assign ready = ((state_q == S_IDLE) && !(rd_en || wr_en)) || (state_q == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Drives sram_controller against a behavioural 16-bit SRAM, using a vector
//   table plus short hand-written sequences (back-to-back, reset mid-access).
module tb_sram_controller;

`ifdef SRAM_FAST_WRITE_EN
  localparam int unsigned AC     = 7;
  localparam int unsigned WR_CYC = 3;
`else
  localparam int unsigned AC     = 5;
  localparam int unsigned WR_CYC = 5;
`endif
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus while oe_n is low, stores while we_n is low.
  logic [15:0] mem [0:262143];
  assign sram_dq = (!sram_oe_n) ? mem[sram_addr] : 16'hzzzz;

  logic [33:0] obs_w [$];   // observed {addr, data} write halves
  logic [33:0] exp_w [$];   // expected write halves
  logic [31:0] exp_rd [$];  // expected read_data at DONE

  always @(negedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] = sram_dq;
      obs_w.push_back({sram_addr, sram_dq});
    end
  end

  int unsigned tests  = 0;
  int unsigned failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [17:0] lo_addr(input logic [31:0] a);
    logic [16:0] w;
    w = 17'((a - BASE) >> 2);
    return {w, 1'b0};
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int unsigned exp_cycles;
  } vec_t;

  task automatic run_vec(input vec_t v, input bit drop);
    int unsigned cyc;
    logic [33:0] e, o;
    @(negedge clk);
    rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
    if (v.wr) begin
      exp_w.push_back({lo_addr(v.addr), v.wdata[15:0]});
      exp_w.push_back({lo_addr(v.addr) | 18'd1, v.wdata[31:16]});
    end
    exp_rd.push_back(v.exp_rdata);
    #1;
    check("ready_low_on_request", {31'd0, ready}, 32'd0);
    cyc = 0;
    while (!ready && cyc < 40) begin
      @(negedge clk);
      // Scramble inputs mid-access; the controller must use latched values.
      address    = v.addr ^ 32'h0000_0FF0;
      write_data = ~v.wdata;
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(v.exp_cycles));
    check("read_data", read_data, exp_rd.pop_front());
    check("write_half_count", 32'(obs_w.size()), 32'(exp_w.size()));
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      e = exp_w.pop_front();
      o = obs_w.pop_front();
      check("write_half_addr", {14'd0, o[33:16]}, {14'd0, e[33:16]});
      check("write_half_data", {16'd0, o[15:0]}, {16'd0, e[15:0]});
    end
    exp_w.delete();
    obs_w.delete();
    address = v.addr; write_data = v.wdata;
    if (drop) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      check("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [10];
  vec_t v;

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    //          rd    wr    address   write_data     exp_rdata      cycles
    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000, WR_CYC};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, AC};
    vecs[2] = '{1'b1, 1'b1, 32'd1036, 32'h12345678, 32'hDEADBEEF, WR_CYC};
    vecs[3] = '{1'b1, 1'b0, 32'd1036, 32'h0,        32'h12345678, AC};
    vecs[4] = '{1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, 32'h12345678, WR_CYC};
    vecs[5] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hA5A55A5A, AC};
    vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'h00000000, AC};
    vecs[7] = '{1'b0, 1'b1, 32'd525308, 32'hCAFEF00D, 32'h00000000, WR_CYC};
    vecs[8] = '{1'b1, 1'b0, 32'd525308, 32'h0,      32'hCAFEF00D, AC};
    vecs[9] = '{1'b1, 1'b0, 32'd525312, 32'h0,      32'hA5A55A5A, AC};

    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rst = 1'b1;
    #1;
    check("reset_read_data", read_data, 32'd0);
    check("reset_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("reset_we_n", {31'd0, sram_we_n}, 32'd1);
    check("reset_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("reset_ready", {31'd0, ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b1);

    // Back-to-back: second read requested in the IDLE cycle right after DONE.
    v = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, AC};
    run_vec(v, 1'b0);
    v = '{1'b1, 1'b0, 32'd1036, 32'h0, 32'h12345678, AC};
    run_vec(v, 1'b1);

    // Reset in the WAIT phase of a read aborts it.
    @(negedge clk);
    rd_en = 1'b1; address = 32'd1040;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_read_data", read_data, 32'd0);
    check("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, AC};
    run_vec(v, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle responder for the data-memory port of the pipelined ARM core. It replaces the single-cycle data memory behind the MEM stage: it accepts the stage's read/write requests and drives an external 16-bit asynchronous SRAM (two half-word accesses per 32-bit word). While an access is in progress it holds `ready` low so the pipeline freezes.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 5: cycles from request to completion; legal range 3..15.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rd_en`  in  1  read request from the MEM stage.
- `wr_en`  in  1  write request from the MEM stage.
- `address`  in  32  byte address, word aligned.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result; registered.
- `ready`  out  1  high means the pipeline may advance; low means freeze.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq`  inout  16  SRAM data bus.
- `sram_we_n`  out  1  SRAM write enable, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  tied 0.

## Operation
- Address map: `word = (address - BASE_ADDR) >> 2`, using the low 17 bits.
  - Low half-word goes to `sram_addr = {word[16:0],1'b0}`.
  - High half-word goes to `sram_addr = {word[16:0],1'b1}`.
- States and transitions:
  - IDLE → RD_LO on `rd_en`, or → WR_LO on `wr_en`.
  - RD_LO → RD_HI; WR_LO → WR_HI.
  - RD_HI / WR_HI → WAIT, or → DONE when `ACCESS_CYCLES`=3.
  - WAIT lasts `ACCESS_CYCLES-3` cycles (4-bit down-counter), then → DONE.
  - DONE → IDLE unconditionally.
- Simultaneous `rd_en` and `wr_en`: the write is taken and the read is ignored.
- On leaving IDLE, `address` and `write_data` are latched. Input changes mid-access are ignored.
- RD_LO: `sram_oe_n`=0, bus released; `read_data[15:0]` captures `sram_dq` at the end of the cycle.
- RD_HI: same, capturing into `read_data[31:16]`.
- WR_LO: `sram_dq` driven with `write_data[15:0]`, `sram_we_n`=0.
- WR_HI: `sram_dq` driven with `write_data[31:16]`, `sram_we_n`=0.
- All other states: `sram_dq` high-Z, `sram_we_n`=1, `sram_oe_n`=1, `sram_addr` holds its last value.
- `ready` (combinational):
  - 1 in IDLE with no request, and 1 in DONE.
  - 0 in IDLE with a request, and 0 in every other state.
- A request still asserted during DONE is the same instruction and does not start a new access.
- `read_data` holds until the next read completes; writes never alter it.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `read_data`=0, `sram_addr`=0;
  - `sram_we_n`=1, `sram_oe_n`=1, `sram_dq` high-Z;
  - `ready`=1 when no request is present.
- A reset asserted mid-access aborts the access immediately (asynchronous). Any partial write is not retried.
- A request seen in IDLE at cycle T0:
  - `ready`=0 during T0..T(ACCESS_CYCLES-1);
  - DONE at T(ACCESS_CYCLES), with `ready`=1 and `read_data` valid;
  - IDLE at T(ACCESS_CYCLES+1).
- Back-to-back requests: each new request is accepted no earlier than the IDLE cycle after DONE. Per-access cost is `ACCESS_CYCLES+1` cycles.
- Outputs `sram_addr`, `sram_we_n`, `sram_oe_n` and the `sram_dq` drive are decoded from the registered state. They are glitch-free relative to `clk`.

## Configuration
- Macro: `SRAM_FAST_WRITE_EN`.
  - Defined: writes skip WAIT, going WR_HI → DONE. A write completes with DONE at T3 regardless of `ACCESS_CYCLES`. Reads are unchanged.
  - Undefined: reads and writes share the `ACCESS_CYCLES` timing.

## Test plan
- Reset values: assert `rst` with no clock edge → `read_data`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq`=Z, `ready`=1.
- Write: `wr_en`=1, `address`=1032, `write_data`=0xDEADBEEF →
  - `sram_addr`=4 with `sram_dq`=0xBEEF, then `sram_addr`=5 with `sram_dq`=0xDEAD, `sram_we_n` low in both;
  - `ready`=0 for 5 cycles, then 1 at T5.
- Read back: `rd_en`=1, `address`=1032, SRAM model returns the stored halves → `read_data`=0xDEADBEEF at T5; the next read starts at T6.
- Simultaneous `rd_en`=`wr_en`=1, `address`=1036, `write_data`=0x12345678 → write to `sram_addr` 6/7 occurs; `read_data` is unchanged.
- Reset during WAIT of a read → next cycle state is IDLE, `read_data`=0, bus high-Z. A following read of 1032 returns 0xDEADBEEF.
- With `SRAM_FAST_WRITE_EN` and `ACCESS_CYCLES`=7 → write reaches DONE at T3, read reaches DONE at T7.
